smpl_queue: RTL and testbench
=============================

// Module: smpl_queue
// PURPOSE
//  Circular stereo sample queue; feeding side of the equalizer FIR bands.
//  - Stores each incoming L/R sample in dual-port RAM.
//  - Once NUM_TAPS samples are held, each new sample triggers a burst
//    that streams the latest NUM_TAPS-sample window (oldest first) on
//    lft_out/rght_out, framed by `sequencing`.
//  - Every FIR_B* band consumes the burst and runs its MAC against its
//    coefficient ROM.
// PARAMETERS
//  DEPTH     1024  RAM words; power of 2. Pointer width PW = $clog2(DEPTH).
//  NUM_TAPS  1021  Window length streamed per burst. Must be < DEPTH.
// PORTS
//  clk         in   1   system clock (single clock domain)
//  rst         in   1   reset: synchronous, active-high
//  wrt_smpl    in   1   1-cycle strobe: lft_smpl/rght_smpl valid
//  lft_smpl    in   16  signed left sample
//  rght_smpl   in   16  signed right sample
//  lft_out     out  16  streamed left sample to the FIRs
//  rght_out    out  16  streamed right sample to the FIRs
//  sequencing  out  1   burst frame, exactly NUM_TAPS+1 cycles high
//  overrun     out  1   sticky: sample arrived while a burst was already pending
// BEHAVIOUR
//  Reset (rst high at posedge)
//  - new_ptr, old_ptr, rd_ptr, fill_cnt, pending = 0; state = IDLE.
//  - sequencing = 0, lft_out = rght_out = 0, overrun = 0. RAM contents not cleared.
//  - Reset mid-burst: sequencing is 0 the next cycle. The queue is empty
//    again, so NUM_TAPS fresh samples are needed before the next burst.
//  Write path (any state)
//  - On wrt_smpl, {lft_smpl,rght_smpl} is written at new_ptr and new_ptr++
//    (mod DEPTH).
//  - While fill_cnt < NUM_TAPS: fill_cnt++ and old_ptr is held.
//  - Once full: old_ptr++ on each write, so old_ptr = new_ptr - NUM_TAPS.
//  - A write that makes or keeps the queue full raises a burst request.
//  FSM states
//  - IDLE: sequencing = 0.
//    - Burst request (or pending): rd_ptr <= window start (post-write
//      old_ptr), clear pending, go to PRIME.
//  - PRIME: sequencing = 1, one cycle.
//    - Issue RAM read at rd_ptr, rd_ptr++, cnt = 0.
//    - Outputs hold their previous value.
//    - The FIRs use this cycle to clear their accumulators.
//  - STREAM: sequencing = 1 for NUM_TAPS cycles.
//    - In cycle k (k = 0..NUM_TAPS-1), lft_out/rght_out = window sample k
//      (registered RAM read data, 1-cycle read latency).
//    - A read is issued each cycle until NUM_TAPS reads total.
//    - After the last cycle, go to IDLE (or to PRIME if pending).
//    - Outputs hold the last sample.
//  - Total sequencing high time = NUM_TAPS+1 cycles; low for at least 1
//    cycle between bursts (IDLE visited).
//  Boundaries
//  - rd_ptr and new_ptr wrap mod DEPTH. A window may straddle address 0.
//  - wrt_smpl during PRIME/STREAM: the sample is written (it lands outside
//    the current window, since DEPTH > NUM_TAPS) and pending is set. The
//    current burst is not disturbed.
//  - Pending burst start: it begins after the current burst and uses the
//    window captured at its own start.
//  - wrt_smpl while pending is already 1: sample stored, overrun <= 1
//    (sticky until rst), still one pending burst.
//  - wrt_smpl in the same cycle as burst end: sets pending (counted).
//  - More than DEPTH-NUM_TAPS writes during one burst corrupt the window
//    (overrun is set before that point).
// STRUCTURE
//  - Shared package eq_pkg: SMPL_W = 16; typedef enum logic [1:0]
//    {Q_IDLE, Q_PRIME, Q_STREAM} q_state_t.
//  - Sub-module dp_ram_smpl
//    - Parameters: DEPTH, width 32.
//    - Ports: 1 write port (we, waddr, wdata); 1 read port (raddr), with
//      registered rdata, 1-cycle latency.
//    - This module holds the pointers, fill counter, burst counter and FSM.
// TESTING (use DEPTH=16, NUM_TAPS=13 unless noted)
//  1. rst, then 12 strobes L=1..12, R=-1..-12 -> sequencing stays 0 and
//     outputs stay 0.
//  2. 13th strobe (L=13) -> sequencing high 14 cycles. In STREAM, L reads
//     1..13 and R reads -1..-13 in order. fill_cnt = 13.
//  3. Strobes 14..20 spaced 20 cycles apart -> each burst streams the last
//     13 samples. Strobe 20 streams 8..20, a window across address 0.
//  4. Strobe during STREAM -> current burst intact. Next burst starts
//     after 1 IDLE cycle and includes the new sample. overrun = 0.
//  5. Two strobes during one STREAM -> overrun = 1 and held. Exactly one
//     extra burst, streaming the newest window.
//  6. rst pulse at STREAM cycle 5 -> sequencing = 0 next cycle. The next
//     13 strobes burst exactly as in test 2.
//     Default params: 1021 strobes -> 1022-cycle burst.

Source files
------------

// File: rtl/eq_pkg.sv
//------------------------------------------------------------------------------
// Package : eq_pkg
// Brief   : Shared types and constants for the equalizer sample path.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package eq_pkg;

  // Width of one signed audio sample (one channel)
  localparam int SMPL_W = 16;

  // Burst sequencer states of the sample queue
  typedef enum logic [1:0] {
    Q_IDLE   = 2'd0,
    Q_PRIME  = 2'd1,
    Q_STREAM = 2'd2
  } q_state_t;

endpackage : eq_pkg

`default_nettype wire

// File: rtl/dp_ram_smpl.sv
//------------------------------------------------------------------------------
// Module : dp_ram_smpl
// Brief  : Simple dual-port RAM, one write port and one read port with a
//          registered read data output (1-cycle latency). The read register
//          only updates on a read enable so it holds its last value.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dp_ram_smpl #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array write; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; reset only clears the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dp_ram_smpl

`default_nettype wire

// File: rtl/smpl_queue.sv
//------------------------------------------------------------------------------
// Module : smpl_queue
// Brief  : Circular stereo sample queue. Once NUM_TAPS samples are held,
//          every new sample triggers a burst streaming the newest
//          NUM_TAPS-sample window (oldest first) to the FIR bands, framed by
//          `sequencing` (one PRIME cycle + NUM_TAPS STREAM cycles).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module smpl_queue
  import eq_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int NUM_TAPS = 1021
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_smpl,
  input  logic [SMPL_W-1:0] lft_smpl,
  input  logic [SMPL_W-1:0] rght_smpl,
  output logic [SMPL_W-1:0] lft_out,
  output logic [SMPL_W-1:0] rght_out,
  output logic              sequencing,
  output logic              overrun
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] TAPS_C   = PW'(NUM_TAPS);
  localparam logic [PW-1:0] LAST_C   = PW'(NUM_TAPS - 1);

  // Write-side pointers and fill level
  logic [PW-1:0] new_ptr_q, new_ptr_d;
  logic [PW-1:0] old_ptr_q, old_ptr_d;
  logic [PW-1:0] fill_cnt_q, fill_cnt_d;

  // Read-side sequencer
  q_state_t      state_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] cnt_q;
  logic          pending_q;
  logic          overrun_q;
  logic          seq_q;

  logic          full;
  logic          burst_req;
  logic          rd_en;
  logic [2*SMPL_W-1:0] rd_data;

  // Next-state of the write pointers; a write that makes or keeps the
  // queue full requests a burst
  always_comb begin
    full       = (fill_cnt_q == TAPS_C);
    burst_req  = wrt_smpl && (fill_cnt_q >= LAST_C);
    new_ptr_d  = new_ptr_q;
    old_ptr_d  = old_ptr_q;
    fill_cnt_d = fill_cnt_q;
    if (wrt_smpl) begin
      new_ptr_d = new_ptr_q + 1'b1;
      if (full) begin
        old_ptr_d = old_ptr_q + 1'b1;
      end else begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
  end

  // Write pointer and fill level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      new_ptr_q  <= '0;
      old_ptr_q  <= '0;
      fill_cnt_q <= '0;
    end else begin
      new_ptr_q  <= new_ptr_d;
      old_ptr_q  <= old_ptr_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // A read is issued in PRIME and in every STREAM cycle but the last, which
  // yields exactly NUM_TAPS reads per burst
  assign rd_en = (state_q == Q_PRIME) ||
                 ((state_q == Q_STREAM) && (cnt_q != LAST_C));

  // Burst sequencer: captures the window start, counts STREAM cycles and
  // tracks one pending burst plus the sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= Q_IDLE;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      case (state_q)
        Q_IDLE: begin
          if (burst_req || pending_q) begin
            rd_ptr_q  <= old_ptr_d;
            pending_q <= 1'b0;
            seq_q     <= 1'b1;
            state_q   <= Q_PRIME;
          end
        end
        Q_PRIME: begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          cnt_q    <= '0;
          state_q  <= Q_STREAM;
          if (burst_req) begin
            pending_q <= 1'b1;
            if (pending_q) overrun_q <= 1'b1;
          end
        end
        Q_STREAM: begin
          if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (burst_req) begin
            pending_q <= 1'b1;
            if (pending_q) overrun_q <= 1'b1;
          end
          // Always pass through IDLE so the frame drops for a cycle
          if (cnt_q == LAST_C) begin
            seq_q   <= 1'b0;
            state_q <= Q_IDLE;
          end
        end
        default: begin
          seq_q   <= 1'b0;
          state_q <= Q_IDLE;
        end
      endcase
    end
  end

  dp_ram_smpl #(
    .DEPTH  (DEPTH),
    .DATA_W (2*SMPL_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wrt_smpl),
    .waddr_i (new_ptr_q),
    .wdata_i ({lft_smpl, rght_smpl}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign lft_out    = rd_data[2*SMPL_W-1:SMPL_W];
  assign rght_out   = rd_data[SMPL_W-1:0];
  assign sequencing = seq_q;
  assign overrun    = overrun_q;

endmodule : smpl_queue

`default_nettype wire

// File: tb/tb_smpl_queue.sv
//------------------------------------------------------------------------------
// Module : tb_smpl_queue
// Brief  : Self-checking bench for smpl_queue (DEPTH=16, NUM_TAPS=13).
//          A history-queue reference model predicts the frame, streamed
//          samples and overrun every cycle; directed tables and sequences
//          check burst counts, windows and corner cases.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_smpl_queue;

  localparam int DEPTH = 16;
  localparam int NT    = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt_smpl;
  logic [15:0] lft_smpl, rght_smpl;
  logic [15:0] lft_out, rght_out;
  logic        sequencing, overrun;

  smpl_queue #(.DEPTH(DEPTH), .NUM_TAPS(NT)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .sequencing (sequencing),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (updated on rising edges) -------------
  logic [15:0] hl[$], hr[$];     // sample history, newest at the back
  logic [15:0] wl[NT], wr[NT];   // window captured at burst start
  int          nwr, rem, pos;
  bit          pend, m_ovr, m_req;
  logic [15:0] m_l, m_r;

  always @(posedge clk) begin
    if (rst) begin
      hl.delete(); hr.delete();
      nwr = 0; rem = 0; pos = 0; pend = 0; m_ovr = 0;
      m_l = '0; m_r = '0;
    end else begin
      m_req = 0;
      if (wrt_smpl) begin
        hl.push_back(lft_smpl);
        hr.push_back(rght_smpl);
        if (hl.size() > DEPTH) begin
          void'(hl.pop_front());
          void'(hr.pop_front());
        end
        nwr++;
        m_req = (nwr >= NT);
      end
      if (rem > 0) begin
        if (m_req) begin
          if (pend) m_ovr = 1;
          pend = 1;
        end
        rem--;
        pos++;
        if (pos >= 1 && pos <= NT) begin
          m_l = wl[pos-1];
          m_r = wr[pos-1];
        end
      end else if (m_req || pend) begin
        pend = 0;
        rem  = NT + 1;
        pos  = 0;
        for (int i = 0; i < NT; i++) begin
          wl[i] = hl[hl.size()-NT+i];
          wr[i] = hr[hr.size()-NT+i];
        end
      end
    end
  end

  // ---------------- checking helpers --------------------------------------
  bit          chk_en = 0;
  int          bursts_seen = 0, low_cnt = 0, last_gap = 0, dut_cyc = 0;
  logic        seq_prev = 1'b0;
  logic [15:0] first_l = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare against the model on the falling edge, then update
  // the burst observers
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("model_seq",  {31'd0, sequencing}, {31'd0, (rem > 0)});
      check("model_lft",  {16'd0, lft_out},    {16'd0, m_l});
      check("model_rght", {16'd0, rght_out},   {16'd0, m_r});
      check("model_ovr",  {31'd0, overrun},    {31'd0, m_ovr});
    end
    if (sequencing && !seq_prev) begin
      bursts_seen++;
      last_gap = low_cnt;
      dut_cyc  = 1;
    end else if (sequencing) begin
      dut_cyc++;
    end
    if (sequencing && dut_cyc == 2) first_l = lft_out;
    if (sequencing) low_cnt = 0; else low_cnt++;
    seq_prev = sequencing;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    wrt_smpl = 1'b1; lft_smpl = l; rght_smpl = r;
    tick();
    wrt_smpl = 1'b0;
  endtask

  // ---------------- directed table: strobe n carries L=n, R=-n ------------
  typedef struct {
    logic [15:0] l, r;
    int          exp_bursts;
    logic [15:0] exp_lout, exp_rout, exp_first;
  } row_t;
  row_t tbl[20];

  task automatic run_rows(input int lo, input int hi, input int base);
    for (int i = lo; i <= hi; i++) begin
      strobe(tbl[i].l, tbl[i].r);
      idle(20);
      check($sformatf("row%0d_bursts", i), bursts_seen - base, tbl[i].exp_bursts);
      check($sformatf("row%0d_lout", i), {16'd0, lft_out},  {16'd0, tbl[i].exp_lout});
      check($sformatf("row%0d_rout", i), {16'd0, rght_out}, {16'd0, tbl[i].exp_rout});
      if (tbl[i].exp_bursts > 0)
        check($sformatf("row%0d_first", i), {16'd0, first_l}, {16'd0, tbl[i].exp_first});
      check($sformatf("row%0d_ovr", i), {31'd0, overrun}, 32'd0);
    end
  endtask

  initial begin
    int b0;
    bit seen;
    for (int i = 0; i < 20; i++) begin
      int n;
      n = i + 1;
      tbl[i].l          = 16'(n);
      tbl[i].r          = 16'(-n);
      tbl[i].exp_bursts = (n >= NT) ? n - NT + 1 : 0;
      tbl[i].exp_lout   = (n >= NT) ? 16'(n)  : 16'd0;
      tbl[i].exp_rout   = (n >= NT) ? 16'(-n) : 16'd0;
      tbl[i].exp_first  = 16'(n - NT + 1);
    end

    rst = 1'b1; wrt_smpl = 1'b0; lft_smpl = '0; rght_smpl = '0;
    idle(2);
    chk_en = 1;
    check("rst_seq",  {31'd0, sequencing}, 32'd0);
    check("rst_lft",  {16'd0, lft_out},    32'd0);
    check("rst_rght", {16'd0, rght_out},   32'd0);
    check("rst_ovr",  {31'd0, overrun},    32'd0);
    rst = 1'b0;
    idle(2);

    // Fill, first burst, and windows through the address-0 wrap
    run_rows(0, 19, bursts_seen);

    // Strobe during STREAM: intact burst, one IDLE cycle, new window
    b0 = bursts_seen;
    strobe(16'd21, 16'(-21));
    idle(3);
    strobe(16'd22, 16'(-22));
    idle(40);
    check("t4_bursts", bursts_seen - b0, 2);
    check("t4_gap",    last_gap, 1);
    check("t4_first",  {16'd0, first_l}, 32'd10);
    check("t4_lout",   {16'd0, lft_out}, 32'd22);
    check("t4_ovr",    {31'd0, overrun}, 32'd0);

    // Two strobes during one STREAM: sticky overrun, one extra burst
    b0 = bursts_seen;
    strobe(16'd23, 16'(-23));
    idle(3);
    strobe(16'd24, 16'(-24));
    idle(2);
    strobe(16'd25, 16'(-25));
    idle(45);
    check("t5_bursts", bursts_seen - b0, 2);
    check("t5_first",  {16'd0, first_l}, 32'd13);
    check("t5_lout",   {16'd0, lft_out}, 32'd25);
    check("t5_ovr",    {31'd0, overrun}, 32'd1);
    idle(20);
    check("t5_ovr_held", {31'd0, overrun}, 32'd1);

    // Reset at STREAM cycle 5
    strobe(16'd26, 16'(-26));
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (sequencing) seen = 1; else tick();
    end
    check("t6_burst_started", {31'd0, seen}, 32'd1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_seq_dropped", {31'd0, sequencing}, 32'd0);
    check("t6_ovr_cleared", {31'd0, overrun},    32'd0);
    idle(3);
    run_rows(0, 12, bursts_seen);

    // Randomised traffic against the model (at most 3 writes per burst)
    for (int i = 0; i < 40; i++) begin
      strobe(16'($urandom), 16'($urandom));
      idle($urandom_range(5, 25));
    end
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_smpl_queue

`default_nettype wire
